// File: rtl/nibble_addsub_arb_pkg.sv
// Shared types and constants for the nibble-serial add/sub arbiter.
package nibble_addsub_arb_pkg;

  localparam int unsigned SliceW = 4;

  localparam logic ModeAdd = 1'b0;
  localparam logic ModeSub = 1'b1;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StDone
  } state_e;

endpackage

// File: rtl/nibble_addsub_arb_addsub_nibble.sv
// Combinational 4-bit add/subtract slice; subtraction inverts b and expects cin=1 on the LS nibble.
module addsub_nibble
  import nibble_addsub_arb_pkg::*;
(
  input  logic [SliceW-1:0] a_i,
  input  logic [SliceW-1:0] b_i,
  input  logic              mode_i,
  input  logic              cin_i,
  output logic [SliceW-1:0] sum_o,
  output logic              cout_o
);

  logic [SliceW-1:0] b_eff;

  assign b_eff = b_i ^ {SliceW{mode_i}};
  assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_eff} + {{SliceW{1'b0}}, cin_i};

endmodule

// File: rtl/nibble_addsub_arb.sv
// Two-requester round-robin front end feeding one serial add/sub datapath, one nibble per cycle.
module nibble_addsub_arb
  import nibble_addsub_arb_pkg::*;
#(
  parameter int unsigned NIBBLES = 4,
  localparam int unsigned W = SliceW * NIBBLES
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         req0_valid_i,
  input  logic         req1_valid_i,
  output logic         req0_ready_o,
  output logic         req1_ready_o,
  input  logic [W-1:0] req0_a_i,
  input  logic [W-1:0] req0_b_i,
  input  logic [W-1:0] req1_a_i,
  input  logic [W-1:0] req1_b_i,
  input  logic         req0_mode_i,
  input  logic         req1_mode_i,
  output logic         rsp_valid_o,
  input  logic         rsp_ready_i,
  output logic [W-1:0] rsp_result_o,
  output logic         rsp_cout_o,
  output logic         rsp_ovf_o,
  output logic         rsp_id_o
);

  localparam int unsigned CntW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  state_e          state_q;
  logic [W-1:0]    a_q, b_q, result_q;
  logic            mode_q, id_q, carry_q, ovf_q, valid_q, prio_q;
  logic [CntW-1:0] cnt_q;

  logic              idle, grant0, grant1, hs, last_nib;
  logic [SliceW-1:0] sum;
  logic              cout;

  // prio_q=1 means requester 1 wins a tie
  assign grant1   = req1_valid_i & (~req0_valid_i | prio_q);
  assign grant0   = req0_valid_i & ~grant1;
  assign idle     = (state_q == StIdle);
  assign req0_ready_o = rst_ni & idle & grant0;
  assign req1_ready_o = rst_ni & idle & grant1;
  assign hs       = req0_ready_o | req1_ready_o;
  assign last_nib = (cnt_q == CntW'(NIBBLES - 1));

  // carry_q is preloaded with the mode on acceptance, giving the +1 for subtraction
  addsub_nibble u_slice (
    .a_i    (a_q[cnt_q*SliceW +: SliceW]),
    .b_i    (b_q[cnt_q*SliceW +: SliceW]),
    .mode_i (mode_q),
    .cin_i  (carry_q),
    .sum_o  (sum),
    .cout_o (cout)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      mode_q   <= ModeAdd;
      id_q     <= 1'b0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      valid_q  <= 1'b0;
      prio_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (hs) begin
            state_q <= StCalc;
            a_q     <= grant1 ? req1_a_i : req0_a_i;
            b_q     <= grant1 ? req1_b_i : req0_b_i;
            mode_q  <= grant1 ? req1_mode_i : req0_mode_i;
            carry_q <= grant1 ? req1_mode_i : req0_mode_i;
            id_q    <= grant1;
            prio_q  <= ~grant1;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
          end
        end
        StCalc: begin
          result_q[cnt_q*SliceW +: SliceW] <= sum;
          carry_q <= cout;
          if (last_nib) begin
            state_q <= StDone;
            valid_q <= 1'b1;
            cnt_q   <= '0;
            ovf_q   <= (a_q[W-1] == (b_q[W-1] ^ mode_q)) & (sum[SliceW-1] != a_q[W-1]);
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StDone: begin
          if (rsp_ready_i) begin
            state_q <= StIdle;
            valid_q <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign rsp_valid_o  = valid_q;
  assign rsp_result_o = result_q;
  assign rsp_cout_o   = carry_q & valid_q;
  assign rsp_ovf_o    = ovf_q;
  assign rsp_id_o     = id_q;

endmodule

// File: tb/tb_nibble_addsub_arb.sv
// Randomized scoreboard bench for nibble_addsub_arb with an arithmetic reference model.
module tb_nibble_addsub_arb;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        req0_valid_i = 1'b0, req1_valid_i = 1'b0;
  logic        req0_ready_o, req1_ready_o;
  logic [15:0] req0_a_i = '0, req0_b_i = '0, req1_a_i = '0, req1_b_i = '0;
  logic        req0_mode_i = 1'b0, req1_mode_i = 1'b0;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b0;
  logic [15:0] rsp_result_o;
  logic        rsp_cout_o, rsp_ovf_o, rsp_id_o;

  nibble_addsub_arb #(.NIBBLES(4)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .req0_valid_i (req0_valid_i),
    .req1_valid_i (req1_valid_i),
    .req0_ready_o (req0_ready_o),
    .req1_ready_o (req1_ready_o),
    .req0_a_i     (req0_a_i),
    .req0_b_i     (req0_b_i),
    .req1_a_i     (req1_a_i),
    .req1_b_i     (req1_b_i),
    .req0_mode_i  (req0_mode_i),
    .req1_mode_i  (req1_mode_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready_i),
    .rsp_result_o (rsp_result_o),
    .rsp_cout_o   (rsp_cout_o),
    .rsp_ovf_o    (rsp_ovf_o),
    .rsp_id_o     (rsp_id_o)
  );

  always #5 clk_i = ~clk_i;

  int unsigned cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        mode;
  } op_t;

  typedef struct {
    logic [15:0] res;
    logic        cout;
    logic        ovf;
    logic        id;
    int unsigned hs_cyc;
  } exp_t;

  exp_t        sb[$];
  op_t         q0[$], q1[$];
  op_t         cur0, cur1;
  int          n_checks = 0, n_pass = 0;
  int unsigned free_cyc = 0;  // first cycle at which the DUT is expected back in idle
  logic        last_g = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp_v, cyc);
  endtask

  // Reference: plain integer arithmetic on the whole 16-bit operands
  function automatic exp_t model(input op_t op, input logic id, input int unsigned c);
    exp_t   e;
    longint ua, ub, full;
    int     sa, sbv, sr;
    ua = longint'(op.a);
    ub = longint'(op.b);
    full = op.mode ? (ua - ub + 65536) : (ua + ub);
    sa = int'($signed(op.a));
    sbv = int'($signed(op.b));
    sr = op.mode ? (sa - sbv) : (sa + sbv);
    e.res = 16'(full % 65536);
    e.cout = (full >= 65536);
    e.ovf = (sr > 32767) || (sr < -32768);
    e.id = id;
    e.hs_cyc = c;
    return e;
  endfunction

  function automatic logic [15:0] rnd16();
    case ($urandom_range(0, 6))
      0: return 16'h0000;
      1: return 16'h0001;
      2: return 16'h7FFF;
      3: return 16'h8000;
      4: return 16'hFFFF;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic apply0();
    req0_a_i = cur0.a; req0_b_i = cur0.b; req0_mode_i = cur0.mode;
  endtask

  task automatic apply1();
    req1_a_i = cur1.a; req1_b_i = cur1.b; req1_mode_i = cur1.mode;
  endtask

  // Monitor: pops and compares whenever a result is presented and consumed
  initial begin
    logic        prev_v, prev_rdy;
    logic [15:0] s_res;
    logic        s_cout, s_ovf, s_id;
    int          hold;
    exp_t        e;
    prev_v = 1'b0; prev_rdy = 1'b0; hold = 0;
    s_res = '0; s_cout = 1'b0; s_ovf = 1'b0; s_id = 1'b0;
    forever begin
      @(negedge clk_i);
      if (!rst_ni) begin
        prev_v = 1'b0; prev_rdy = 1'b0; rsp_ready_i = 1'b0;
        continue;
      end
      if (prev_v && prev_rdy) check("idle_after_consume", rsp_valid_o, 0);
      if (rsp_valid_o && !(prev_v && !prev_rdy)) begin
        check("rsp_expected", sb.size() != 0, 1);
        if (sb.size() != 0) check("latency", cyc - sb[0].hs_cyc, 5);
        s_res = rsp_result_o; s_cout = rsp_cout_o; s_ovf = rsp_ovf_o; s_id = rsp_id_o;
        hold = $urandom_range(0, 4);
      end else if (rsp_valid_o) begin
        check("rsp_stable", {rsp_result_o, rsp_cout_o, rsp_ovf_o, rsp_id_o},
              {s_res, s_cout, s_ovf, s_id});
      end
      rsp_ready_i = rsp_valid_o && (hold == 0);
      if (hold > 0) hold--;
      if (rsp_ready_i && sb.size() != 0) begin
        e = sb.pop_front();
        check("result", rsp_result_o, e.res);
        check("cout", rsp_cout_o, e.cout);
        check("ovf", rsp_ovf_o, e.ovf);
        check("id", rsp_id_o, e.id);
        free_cyc = cyc + 1;
      end
      prev_v = rsp_valid_o;
      prev_rdy = rsp_ready_i;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // Stimulus
  initial begin
    logic hs0, hs1, r0, r1, exp_g, exp_idle;
    int   n;
    hs0 = 1'b0; hs1 = 1'b0;

    q0.push_back('{16'h1234, 16'h0FCD, 1'b0});
    q0.push_back('{16'h7FFF, 16'h0001, 1'b0});
    q0.push_back('{16'hFFFF, 16'h0001, 1'b0});
    q0.push_back('{16'h8000, 16'h0001, 1'b1});
    q1.push_back('{16'h0005, 16'h0007, 1'b1});
    q1.push_back('{16'h0007, 16'h0005, 1'b1});
    for (int i = 0; i < 25; i++) begin
      q0.push_back('{rnd16(), rnd16(), 1'($urandom_range(0, 1))});
      q1.push_back('{rnd16(), rnd16(), 1'($urandom_range(0, 1))});
    end

    // Both requesters valid throughout reset
    cur0 = q0.pop_front(); apply0(); req0_valid_i = 1'b1;
    cur1 = q1.pop_front(); apply1(); req1_valid_i = 1'b1;
    #22;
    check("rst_ready0", req0_ready_o, 0);
    check("rst_ready1", req1_ready_o, 0);
    check("rst_valid", rsp_valid_o, 0);
    check("rst_result", rsp_result_o, 0);
    check("rst_flags", {rsp_cout_o, rsp_ovf_o, rsp_id_o}, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    free_cyc = 0;

    n = 0;
    while (n < 6000 && (q0.size() != 0 || q1.size() != 0 || req0_valid_i || req1_valid_i)) begin
      if (n != 0) @(negedge clk_i);
      n++;
      if (hs0) begin req0_valid_i = 1'b0; hs0 = 1'b0; end
      if (hs1) begin req1_valid_i = 1'b0; hs1 = 1'b0; end
      if (!req0_valid_i && q0.size() != 0 && $urandom_range(0, 3) != 0) begin
        cur0 = q0.pop_front(); apply0(); req0_valid_i = 1'b1;
      end
      if (!req1_valid_i && q1.size() != 0 && $urandom_range(0, 3) != 0) begin
        cur1 = q1.pop_front(); apply1(); req1_valid_i = 1'b1;
      end
      #1;
      r0 = req0_ready_o;
      r1 = req1_ready_o;
      exp_idle = (cyc >= free_cyc);
      if (r0 || r1) check("ready_needs_valid", (r0 && !req0_valid_i) || (r1 && !req1_valid_i), 0);
      if (req0_valid_i || req1_valid_i) begin
        if (exp_idle) begin
          exp_g = (req0_valid_i && req1_valid_i) ? ~last_g : req1_valid_i;
          check("grant0", r0, exp_g == 1'b0);
          check("grant1", r1, exp_g == 1'b1);
        end else begin
          check("no_grant_busy", r0 | r1, 0);
        end
      end
      if (r0 && req0_valid_i) begin
        sb.push_back(model(cur0, 1'b0, cyc));
        last_g = 1'b0; free_cyc = '1; hs0 = 1'b1;
      end else if (r1 && req1_valid_i) begin
        sb.push_back(model(cur1, 1'b1, cyc));
        last_g = 1'b1; free_cyc = '1; hs1 = 1'b1;
      end
    end
    check("stream_done", n < 6000, 1);

    n = 0;
    while (sb.size() != 0 && n < 200) begin @(negedge clk_i); n++; end
    check("drain", sb.size(), 0);

    // Reset in the third computation cycle discards the operation in flight
    @(negedge clk_i);
    cur0 = '{16'hABCD, 16'h1357, 1'b1}; apply0(); req0_valid_i = 1'b1;
    #1;
    check("rst_test_grant", req0_ready_o, 1);
    @(negedge clk_i);
    req0_valid_i = 1'b0;
    cur1 = '{16'h4321, 16'h0ABC, 1'b0}; apply1(); req1_valid_i = 1'b1;
    @(negedge clk_i);
    @(negedge clk_i);
    #2 rst_ni = 1'b0;
    #1;
    check("async_rst_valid", rsp_valid_o, 0);
    check("async_rst_result", rsp_result_o, 0);
    check("async_rst_flags", {rsp_cout_o, rsp_ovf_o, rsp_id_o}, 0);
    check("async_rst_ready", {req0_ready_o, req1_ready_o}, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    last_g = 1'b1;
    free_cyc = 0;
    #1;
    check("post_rst_grant", req1_ready_o, 1);
    sb.push_back(model(cur1, 1'b1, cyc));
    free_cyc = '1;
    @(negedge clk_i);
    req1_valid_i = 1'b0;
    n = 0;
    while (sb.size() != 0 && n < 100) begin @(negedge clk_i); n++; end
    check("post_rst_drain", sb.size(), 0);

    repeat (3) @(negedge clk_i);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/nibble_addsub_arb.md
NIBBLE_ADDSUB_ARB -- requirements
Module: nibble_addsub_arb

Interface
REQ-001 SHALL have parameter NIBBLES, default 4, the number of 4-bit slices per operand (operand width W = 4*NIBBLES).
REQ-002 SHALL have one clock and an asynchronous active-low reset, with ports listed in the order below.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 req0_valid / req1_valid  input  1  requester n has an operation pending.
REQ-006 req0_ready / req1_ready  output  1  operation from requester n is accepted this cycle.
REQ-007 req0_a, req0_b, req1_a, req1_b  input  W  operands.
REQ-008 req0_mode / req1_mode  input  1  0 = a+b, 1 = a-b.
REQ-009 rsp_valid  output  1  a result is presented.
REQ-010 rsp_ready  input  1  the consumer accepts the result.
REQ-011 rsp_result  output  W  sum or difference, modulo 2^W.
REQ-012 rsp_cout  output  1  final carry; for subtraction, 1 = no borrow (a>=b unsigned).
REQ-013 rsp_ovf  output  1  two's-complement overflow.
REQ-014 rsp_id  output  1  index of the requester that owns the result.

Function
REQ-015 SHALL compute each W-bit operation serially through one 4-bit add/sub slice, least-significant nibble first, one nibble per cycle.
REQ-016 FSM states SHALL be IDLE, CALC and DONE.
REQ-017 Transitions: IDLE->CALC on handshake; CALC->DONE after nibble NIBBLES-1; DONE->IDLE on rsp_ready.
REQ-018 A handshake is reqn_valid & reqn_ready; operands, mode and id SHALL be latched on the handshake cycle.
REQ-019 reqn_ready SHALL be asserted only in IDLE, only for the granted requester, and never for both requesters in the same cycle.
REQ-020 Arbitration SHALL be round-robin: a lone valid requester is granted; under contention the requester not granted last wins; the priority pointer resets to favour requester 0.
REQ-021 Slice inputs for nibble k: a nibble k, b nibble k XOR {4{mode}}, carry-in = mode for k=0, else the registered carry-out of nibble k-1.
REQ-022 Latency SHALL be fixed: handshake at cycle T -> rsp_valid asserted at T+NIBBLES+1 (T+5 at default).
REQ-023 rsp_ovf SHALL be (a[W-1] == b_eff[W-1]) & (result[W-1] != a[W-1]), where b_eff is b after mode inversion.
REQ-024 In DONE, all rsp_* outputs SHALL hold stable until rsp_ready is sampled high.
REQ-025 rsp_valid SHALL be 0 in IDLE and CALC.
REQ-026 A new handshake SHALL NOT occur in the same cycle the result is consumed; the next grant occurs one cycle later, in IDLE.
REQ-027 Requests that arrive while the block is busy SHALL wait; the block holds no queue, and the requester keeps valid asserted.

Reset
REQ-028 On rst_n low, the FSM SHALL enter IDLE immediately, including mid-CALC or in DONE; any in-flight operation is discarded.
REQ-029 Reset values SHALL be: reqn_ready=0, rsp_valid=0, rsp_result=0, rsp_cout=0, rsp_ovf=0, rsp_id=0, nibble counter=0, carry=0, priority pointer=requester 0.
REQ-030 The first handshake SHALL be possible in the first clock edge after rst_n deasserts.

Structure
REQ-031 A shared package SHALL hold the FSM state enum, the 4-bit slice width constant and the mode encodings (ADD=0, SUB=1).
REQ-032 A single sub-module, addsub_nibble, SHALL provide the combinational 4-bit slice (inputs a, b, mode, cin; outputs sum, cout); the controller instantiates exactly one.
REQ-033 The result SHALL be assembled in a shift or indexed register; no W-bit adder SHALL be inferred.

Verification
REQ-034 req0 only, a=0x1234, b=0x0FCD, mode=0 -> rsp_result=0x2201, cout=0, ovf=0, id=0, exactly 5 cycles after the handshake.
REQ-035 req1 only, a=0x0005, b=0x0007, mode=1 -> 0xFFFE, cout=0, ovf=0, id=1; then a=0x0007, b=0x0005, mode=1 -> 0x0002, cout=1.
REQ-036 Boundaries: 0x7FFF+0x0001 -> 0x8000, ovf=1, cout=0; 0xFFFF+0x0001 -> 0x0000, cout=1, ovf=0; 0x8000-0x0001 -> 0x7FFF, ovf=1.
REQ-037 Both valid from reset, held high -> grants alternate 0,1,0,1; each readyn pulse lasts one cycle; the two readies are never high together.
REQ-038 rsp_ready held low 3 cycles in DONE -> rsp_* stable throughout, no new grant; rsp_ready high -> IDLE next cycle.
REQ-039 rst_n pulsed low at the third CALC cycle -> outputs reach their reset values asynchronously; the next operation after reset returns a correct result with no residue from the discarded operation.
